// File: rtl/multi_port_fwft_fifo.sv
// Multi-port first-word-fall-through FIFO.
// Writes compact into consecutive slots; reads pop a leading run of ports.
module multi_port_fwft_fifo #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 4,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int NUM_READ_PORTS  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic                                  stat_clr,
  input  logic [ADDR_WIDTH:0]                   af_thresh,
  input  logic [ADDR_WIDTH:0]                   ae_thresh,
  input  logic [NUM_WRITE_PORTS-1:0]            wr_en,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WRITE_PORTS-1:0]            wr_ready,
  input  logic [NUM_READ_PORTS-1:0]             rd_en,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ_PORTS-1:0]             rd_valid,
  output logic [ADDR_WIDTH:0]                   data_count,
  output logic [ADDR_WIDTH:0]                   free_count,
  output logic                                  full,
  output logic                                  empty,
  output logic                                  almost_full,
  output logic                                  almost_empty,
  output logic                                  overflow,
  output logic                                  underflow,
  output logic [ADDR_WIDTH:0]                   high_water
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [ADDR_WIDTH-1:0] idx_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  cnt_t wr_ptr;
  cnt_t rd_ptr;
  cnt_t count;
  cnt_t hw_q;
  cnt_t nw;
  cnt_t nr;
  cnt_t count_nxt;

  logic [NUM_WRITE_PORTS-1:0] wr_acc;
  idx_t                       wr_idx [NUM_WRITE_PORTS];
  logic [NUM_READ_PORTS-1:0]  rd_acc;
  logic                       run;
  logic                       ovf_set;
  logic                       unf_set;

  assign free_count = cnt_t'(DEPTH) - count;

  for (genvar w = 0; w < NUM_WRITE_PORTS; w++) begin : g_wr
    assign wr_ready[w] = free_count > cnt_t'(w);
  end

  for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_rd
    assign rd_valid[r] = count > cnt_t'(r);
    assign rd_data[r*DATA_WIDTH +: DATA_WIDTH] =
      mem[rd_ptr[ADDR_WIDTH-1:0] + idx_t'(r)];
  end

  // Ready ports form a prefix, so a running count gives each slot.
  always_comb begin
    nw      = '0;
    ovf_set = 1'b0;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      wr_acc[w] = wr_en[w] & wr_ready[w];
      wr_idx[w] = wr_ptr[ADDR_WIDTH-1:0] + nw[ADDR_WIDTH-1:0];
      ovf_set   = ovf_set | (wr_en[w] & ~wr_ready[w]);
      nw        = nw + cnt_t'(wr_acc[w]);
    end
  end

  always_comb begin
    nr      = '0;
    unf_set = 1'b0;
    run     = 1'b1;
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      rd_acc[r] = run & rd_en[r] & rd_valid[r];
      run       = rd_acc[r];
      unf_set   = unf_set | (rd_en[r] & ~rd_acc[r]);
      nr        = nr + cnt_t'(rd_acc[r]);
    end
  end

  assign count_nxt = count + nw - nr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + nw;
      rd_ptr <= rd_ptr + nr;
      count  <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (wr_acc[w]) begin
          mem[wr_idx[w]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Error flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      hw_q      <= '0;
    end else begin
      overflow  <= (ovf_set & ~flush) | (overflow & ~stat_clr);
      underflow <= (unf_set & ~flush) | (underflow & ~stat_clr);
      if (stat_clr) begin
        hw_q <= count;
      end else if (!flush && count_nxt > hw_q) begin
        hw_q <= count_nxt;
      end
    end
  end

  assign data_count   = count;
  assign high_water   = hw_q;
  assign full         = count == cnt_t'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= af_thresh;
  assign almost_empty = count <= ae_thresh;

endmodule

// File: tb/tb_multi_port_fwft_fifo.sv
// Bench for multi_port_fwft_fifo: queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_multi_port_fwft_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NW    = 2;
  localparam int NR    = 2;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic           stat_clr;
  logic [AW:0]    af_thresh;
  logic [AW:0]    ae_thresh;
  logic [NW-1:0]  wr_en;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]  wr_ready;
  logic [NR-1:0]  rd_en;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_valid;
  logic [AW:0]    data_count;
  logic [AW:0]    free_count;
  logic           full;
  logic           empty;
  logic           almost_full;
  logic           almost_empty;
  logic           overflow;
  logic           underflow;
  logic [AW:0]    high_water;

  multi_port_fwft_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_WRITE_PORTS(NW),
    .NUM_READ_PORTS(NR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .stat_clr(stat_clr),
    .af_thresh(af_thresh),
    .ae_thresh(ae_thresh),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .data_count(data_count),
    .free_count(free_count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow),
    .high_water(high_water)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the FIFO is just an ordered queue of words.
  logic [DW-1:0] q[$];
  logic [DW-1:0] acc_w[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  int   m_hw  = 0;
  int   m_n, m_free, m_nr;
  logic m_os, m_us, m_run;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_hw  = 0;
    end else begin
      m_n    = q.size();
      m_free = DEPTH - m_n;
      m_os   = 1'b0;
      m_us   = 1'b0;
      m_nr   = 0;
      m_run  = 1'b1;
      acc_w.delete();
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w]) begin
          if (w < m_free) acc_w.push_back(wr_data[w*DW +: DW]);
          else m_os = 1'b1;
        end
      end
      for (int r = 0; r < NR; r++) begin
        if (m_run && rd_en[r] && r < m_n) m_nr++;
        else begin
          m_run = 1'b0;
          if (rd_en[r]) m_us = 1'b1;
        end
      end
      if (flush) begin
        q.delete();
        m_os = 1'b0;
        m_us = 1'b0;
      end else begin
        repeat (m_nr) void'(q.pop_front());
        foreach (acc_w[i]) q.push_back(acc_w[i]);
      end
      m_ovf = m_os | (m_ovf & ~stat_clr);
      m_unf = m_us | (m_unf & ~stat_clr);
      if (stat_clr) m_hw = m_n;
      else if (q.size() > m_hw) m_hw = q.size();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(data_count), 32'(q.size()));
      chk("free", 32'(free_count), 32'(DEPTH - q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("afull", 32'(almost_full), 32'(q.size() >= int'(af_thresh)));
      chk("aempty", 32'(almost_empty), 32'(q.size() <= int'(ae_thresh)));
      chk("ovf", 32'(overflow), 32'(m_ovf));
      chk("unf", 32'(underflow), 32'(m_unf));
      chk("hw", 32'(high_water), 32'(m_hw));
      for (int w = 0; w < NW; w++)
        chk("wr_ready", 32'(wr_ready[w]), 32'((DEPTH - q.size()) > w));
      for (int r = 0; r < NR; r++) begin
        chk("rd_valid", 32'(rd_valid[r]), 32'(q.size() > r));
        if (q.size() > r) chk("rd_data", rd_data[r*DW +: DW], q[r]);
      end
    end
  end

  task automatic drive(input logic [1:0] we, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [1:0] re,
                       input logic fl, input logic sc);
    wr_en    = we;
    wr_data  = {d1, d0};
    rd_en    = re;
    flush    = fl;
    stat_clr = sc;
    @(posedge clk);
    #1;
    wr_en    = '0;
    rd_en    = '0;
    flush    = 1'b0;
    stat_clr = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    stat_clr  = 1'b0;
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    wr_en     = '0;
    wr_data   = '0;
    rd_en     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_free", 32'(free_count), 32'd16);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd3);
    rst_n = 1'b1;

    // Single write on port 1 lands in slot 0.
    drive(2'b10, 32'h0, 32'hB1, 2'b00, 1'b0, 1'b0);
    chk("p1_valid", 32'(rd_valid), 32'd1);
    chk("p1_data", rd_data[31:0], 32'hB1);
    chk("p1_count", 32'(data_count), 32'd1);

    for (int i = 0; i < 7; i++)
      drive(2'b11, 32'h100 + 2*i, 32'h101 + 2*i, 2'b00, 1'b0, 1'b0);
    chk("fill_count", 32'(data_count), 32'd15);
    chk("fill_ready", 32'(wr_ready), 32'd1);
    drive(2'b11, 32'hF0, 32'hF1, 2'b00, 1'b0, 1'b0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(data_count), 32'd16);

    drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_hw", 32'(high_water), 32'd16);
    for (int i = 0; i < 8; i++) drive(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Gapped read request pops nothing.
    drive(2'b11, 32'hA, 32'hB, 2'b00, 1'b0, 1'b0);
    drive(2'b11, 32'hC, 32'hD, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 0, 0, 2'b10, 1'b0, 1'b0);
    chk("gap_unf", 32'(underflow), 32'd1);
    chk("gap_count", 32'(data_count), 32'd4);
    drive(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
    chk("pop_d0", rd_data[31:0], 32'hC);
    chk("pop_d1", rd_data[63:32], 32'hD);
    chk("pop_count", 32'(data_count), 32'd2);

    drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b1);
    chk("clr_unf", 32'(underflow), 32'd0);
    drive(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
    drive(2'b11, 32'h900, 32'h901, 2'b00, 1'b0, 1'b0);
    drive(2'b11, 32'h902, 32'h903, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b1);
    chk("wrap_hw0", 32'(high_water), 32'd4);
    for (int i = 0; i < 40; i++)
      drive(2'b11, 32'h1000 + 2*i, 32'h1001 + 2*i, 2'b11, 1'b0, 1'b0);
    chk("wrap_count", 32'(data_count), 32'd4);
    chk("wrap_hw", 32'(high_water), 32'd4);
    chk("wrap_d0", rd_data[31:0], 32'h104C);
    chk("wrap_d1", rd_data[63:32], 32'h104D);

    drive(2'b11, 32'h2000, 32'h2001, 2'b00, 1'b0, 1'b0);
    drive(2'b11, 32'h2002, 32'h2003, 2'b00, 1'b0, 1'b0);
    chk("pre_flush", 32'(data_count), 32'd8);
    drive(2'b11, 32'h2004, 32'h2005, 2'b00, 1'b1, 1'b0);
    chk("fl_count", 32'(data_count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_ovf", 32'(overflow), 32'd0);
    chk("fl_hw", 32'(high_water), 32'd8);
    drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b1);
    chk("fl_hw_clr", 32'(high_water), 32'd0);

    drive(2'b01, 32'h3000, 0, 2'b00, 1'b0, 1'b0);
    drive(2'b11, 32'h3001, 32'h3002, 2'b00, 1'b0, 1'b0);
    chk("ae_at3", 32'(almost_empty), 32'd1);
    chk("af_at3", 32'(almost_full), 32'd0);
    for (int i = 0; i < 4; i++)
      drive(2'b11, 32'h3100 + 2*i, 32'h3101 + 2*i, 2'b00, 1'b0, 1'b0);
    drive(2'b01, 32'h3200, 0, 2'b00, 1'b0, 1'b0);
    chk("af_at12", 32'(almost_full), 32'd1);
    chk("ae_at12", 32'(almost_empty), 32'd0);
    drive(2'b00, 0, 0, 2'b10, 1'b0, 1'b0);
    chk("pre_rst_unf", 32'(underflow), 32'd1);

    // Reset under full traffic.
    rst_n = 1'b0;
    drive(2'b11, 32'h4000, 32'h4001, 2'b11, 1'b0, 1'b0);
    chk("mr_count", 32'(data_count), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_full", 32'(full), 32'd0);
    chk("mr_free", 32'(free_count), 32'd16);
    chk("mr_valid", 32'(rd_valid), 32'd0);
    chk("mr_ready", 32'(wr_ready), 32'd3);
    chk("mr_hw", 32'(high_water), 32'd0);
    chk("mr_ovf", 32'(overflow), 32'd0);
    chk("mr_unf", 32'(underflow), 32'd0);
    chk("mr_afull", 32'(almost_full), 32'd0);
    chk("mr_aempty", 32'(almost_empty), 32'd1);
    rst_n = 1'b1;
    repeat (3) drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
